// File: rtl/uart_arb_defs_pkg.sv
//==============================================================================
// Module      : uart_arb_defs_pkg
// Description : Shared state encodings and constants for the UART TX arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_arb_defs_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_PREFIX = 2'd1,
        STATE_XFER   = 2'd2
    } arb_state_t;

    // Upper nibble of the per-source identification byte.
    localparam logic [7:0] ID_PREFIX = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
//==============================================================================
// Module      : rr_priority_encoder
// Description : Combinational round-robin picker: first set request above ptr.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_priority_encoder #(
    parameter  int PORTS    = 4,
    localparam int ID_WIDTH = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [PORTS-1:0]    gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                valid
);

    int                  w_cand;
    logic [ID_WIDTH-1:0] w_cand_idx;

    // Search starts one past the last winner and wraps, so ptr itself is lowest priority.
    always_comb begin
        gnt        = '0;
        idx        = '0;
        valid      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 1; k <= PORTS; k++) begin
            w_cand     = (int'(ptr) + k) % PORTS;
            w_cand_idx = w_cand[ID_WIDTH-1:0];
            if (!valid && req[w_cand_idx]) begin
                valid           = 1'b1;
                idx             = w_cand_idx;
                gnt[w_cand_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing one UART TX stream.
//               Optional macro UART_TX_ARB_ID_PREFIX_EN adds a source-ID byte.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_defs_pkg::*;
#(
    parameter  int PORTS      = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_WIDTH   = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [PORTS-1:0]            grant,
    output logic [ID_WIDTH-1:0]         grant_index,
    output logic                        busy
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [PORTS-1:0]      r_grant;
    logic [ID_WIDTH-1:0]   r_grant_index;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;

    logic [PORTS-1:0]      w_enc_gnt;
    logic [ID_WIDTH-1:0]   w_enc_idx;
    logic                  w_enc_valid;
    logic                  w_out_ready;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_valid;
    logic                  w_src_last;
    logic                  w_accept;
    logic                  w_accept_last;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load_last;

    rr_priority_encoder #(
        .PORTS (PORTS)
    ) u_rr_enc (
        .req   (s_axis_tvalid),
        .ptr   (r_ptr),
        .gnt   (w_enc_gnt),
        .idx   (w_enc_idx),
        .valid (w_enc_valid)
    );

    // Output register can take a new byte when empty or being drained this cycle.
    assign w_out_ready = ~r_m_tvalid | m_axis_tready;

    always_comb begin
        w_src_data  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (r_grant[i]) begin
                w_src_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_src_valid = s_axis_tvalid[i];
                w_src_last  = s_axis_tlast[i];
            end
        end
    end

    assign w_accept      = (r_state == STATE_XFER) & w_src_valid & w_out_ready;
    assign w_accept_last = w_accept & w_src_last;
    assign s_axis_tready = ((r_state == STATE_XFER) && w_out_ready) ? r_grant : '0;

    always_comb begin
        w_load      = w_accept;
        w_load_data = w_src_data;
        w_load_last = w_src_last;
`ifdef UART_TX_ARB_ID_PREFIX_EN
        if ((r_state == STATE_PREFIX) && w_out_ready) begin
            w_load      = 1'b1;
            w_load_data = DATA_WIDTH'(ID_PREFIX) | DATA_WIDTH'(r_grant_index);
            w_load_last = 1'b0;
        end
`endif
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            STATE_IDLE: begin
                if (w_enc_valid) begin
`ifdef UART_TX_ARB_ID_PREFIX_EN
                    w_next_state = STATE_PREFIX;
`else
                    w_next_state = STATE_XFER;
`endif
                end
            end
            STATE_PREFIX: begin
`ifdef UART_TX_ARB_ID_PREFIX_EN
                if (w_out_ready) begin
                    w_next_state = STATE_XFER;
                end
`else
                w_next_state = STATE_IDLE;
`endif
            end
            STATE_XFER: begin
                if (w_accept_last) begin
                    w_next_state = STATE_IDLE;
                end
            end
            default: w_next_state = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= STATE_IDLE;
            r_grant       <= '0;
            r_grant_index <= '0;
            r_ptr         <= ID_WIDTH'(PORTS - 1);
        end else begin
            r_state <= w_next_state;
            if ((r_state == STATE_IDLE) && w_enc_valid) begin
                r_grant       <= w_enc_gnt;
                r_grant_index <= w_enc_idx;
            end else if (w_accept_last) begin
                r_ptr         <= r_grant_index;
                r_grant       <= '0;
                r_grant_index <= '0;
            end
        end
    end

    // Holds its contents under backpressure; clears once consumed with nothing new behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            r_m_tdata  <= w_load_data;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_load_last;
        end else if (m_axis_tready) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign grant         = r_grant;
    assign grant_index   = r_grant_index;
    assign busy          = (r_state != STATE_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [PORTS*DW-1:0]  s_tdata;
    logic [PORTS-1:0]     s_tvalid;
    logic [PORTS-1:0]     s_tready;
    logic [PORTS-1:0]     s_tlast;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;
    logic [PORTS-1:0]     grant;
    logic [1:0]           grant_index;
    logic                 busy;

    int pass_cnt = 0;
    int total    = 0;

    logic [7:0]       src_data [PORTS][8];
    int               src_len  [PORTS];
    int               src_pos  [PORTS];
    logic [PORTS-1:0] src_en;
    logic [PORTS-1:0] acc;
    logic [8:0]       out_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant         (grant),
        .grant_index   (grant_index),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] q_at(input int k);
        if (k < out_q.size()) return out_q[k];
        return 9'h1FF;
    endfunction

    task automatic drive();
        for (int i = 0; i < PORTS; i++) begin
            if (src_en[i] && src_pos[i] < src_len[i]) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = src_data[i][src_pos[i]];
                s_tlast[i]           = (src_pos[i] == src_len[i] - 1);
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
                s_tlast[i]           = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes just before the edge, advance sources just after it.
    task automatic cycle();
        drive();
        #1;
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
        @(posedge clk);
        #1;
        for (int i = 0; i < PORTS; i++) if (acc[i]) src_pos[i]++;
        drive();
        #1;
    endtask

    task automatic load(input int p, input int len, input logic [7:0] base);
        src_len[p] = len;
        src_pos[p] = 0;
        for (int k = 0; k < len; k++) src_data[p][k] = base + 8'(k);
        src_en[p] = 1'b1;
    endtask

    task automatic wait_q(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            cycle();
            c++;
        end
        check(tag, out_q.size(), n);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        src_en  = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_q.delete();
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        m_tready = 1'b0;
        src_en   = '0;
        for (int i = 0; i < PORTS; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_grant", grant, 0);
        check("rst_grant_index", grant_index, 0);
        check("rst_busy", busy, 0);
        check("rst_s_tready", s_tready, 0);
        reset_n = 1'b1;
        #1;

`ifdef UART_TX_ARB_ID_PREFIX_EN
        // Port 3 single-byte packet framed by its ID byte.
        m_tready = 1'b1;
        load(3, 1, 8'h55);
        cycle();
        check("pfx_grant", grant, 4'b1000);
        check("pfx_s_tready_low", s_tready, 0);
        cycle();
        check("pfx_byte", m_tdata, 8'hF3);
        check("pfx_tlast", m_tlast, 0);
        check("pfx_valid", m_tvalid, 1);
        cycle();
        check("pfx_payload", m_tdata, 8'h55);
        check("pfx_payload_last", m_tlast, 1);
        check("pfx_busy_done", busy, 0);
`else
        // Single port: port 1 sends 41,42,43(last).
        m_tready = 1'b1;
        load(1, 3, 8'h41);
        drive();
        #1;
        check("t1_no_accept_decision", s_tready, 0);
        cycle();
        check("t1_grant", grant, 4'b0010);
        check("t1_grant_index", grant_index, 1);
        check("t1_busy", busy, 1);
        check("t1_m_tvalid_empty", m_tvalid, 0);
        check("t1_s_tready", s_tready, 4'b0010);
        cycle();
        check("t1_b0", {m_tvalid, m_tlast, m_tdata}, {2'b10, 8'h41});
        cycle();
        check("t1_b1", {m_tvalid, m_tlast, m_tdata}, {2'b10, 8'h42});
        check("t1_grant_mid", grant, 4'b0010);
        cycle();
        check("t1_b2", {m_tvalid, m_tlast, m_tdata}, {2'b11, 8'h43});
        check("t1_busy_fall", busy, 0);
        check("t1_grant_drop", grant, 0);
        cycle();
        check("t1_drained", m_tvalid, 0);
        check("t1_q_size", out_q.size(), 3);
        check("t1_q2", q_at(2), {1'b1, 8'h43});

        // Contention after reset: ports 0, 2, 3 request together.
        do_reset();
        load(0, 2, 8'hA0);
        load(2, 2, 8'hC0);
        load(3, 2, 8'hD0);
        wait_q("t2_count", 6, 40);
        check("t2_q0", q_at(0), {1'b0, 8'hA0});
        check("t2_q1", q_at(1), {1'b1, 8'hA1});
        check("t2_q2", q_at(2), {1'b0, 8'hC0});
        check("t2_q3", q_at(3), {1'b1, 8'hC1});
        check("t2_q4", q_at(4), {1'b0, 8'hD0});
        check("t2_q5", q_at(5), {1'b1, 8'hD1});
        out_q.delete();
        src_en = '0;
        load(0, 1, 8'hB0);
        load(3, 1, 8'hE0);
        cycle();
        check("t2_wrap_grant", grant, 4'b0001);
        wait_q("t2_wrap_count", 2, 20);
        check("t2_wrap_q0", q_at(0), {1'b1, 8'hB0});
        check("t2_wrap_q1", q_at(1), {1'b1, 8'hE0});

        // Backpressure: ready pattern 1,0,0,1 mid-packet.
        out_q.delete();
        src_en = '0;
        load(1, 4, 8'h10);
        cycle();
        cycle();
        check("t3_first", m_tdata, 8'h10);
        cycle();
        check("t3_second", m_tdata, 8'h11);
        m_tready = 1'b0;
        #1;
        check("t3_stall_s_tready0", s_tready, 0);
        cycle();
        check("t3_hold0", {m_tvalid, m_tdata}, {1'b1, 8'h11});
        check("t3_stall_s_tready1", s_tready, 0);
        cycle();
        check("t3_hold1", {m_tvalid, m_tdata}, {1'b1, 8'h11});
        m_tready = 1'b1;
        cycle();
        check("t3_resume", m_tdata, 8'h12);
        wait_q("t3_count", 4, 20);
        cycle();
        check("t3_no_dup", out_q.size(), 4);
        check("t3_q1", q_at(1), {1'b0, 8'h11});
        check("t3_q2", q_at(2), {1'b0, 8'h12});
        check("t3_q3", q_at(3), {1'b1, 8'h13});

        // Source gap: port 2 stalls 5 cycles while port 0 waits.
        out_q.delete();
        src_en = '0;
        load(2, 3, 8'h20);
        cycle();
        cycle();
        src_en[2] = 1'b0;
        load(0, 1, 8'h30);
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("t4_grant_held", grant, 4'b0100);
        end
        src_en[2] = 1'b1;
        wait_q("t4_count", 4, 30);
        check("t4_q1", q_at(1), {1'b0, 8'h21});
        check("t4_q2", q_at(2), {1'b1, 8'h22});
        check("t4_q3", q_at(3), {1'b1, 8'h30});

        // Reset mid-packet after byte 2 of 4.
        out_q.delete();
        src_en = '0;
        load(1, 4, 8'h50);
        cycle();
        cycle();
        cycle();
        check("t5_pre_reset", m_tdata, 8'h51);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_tvalid", m_tvalid, 0);
        check("t5_async_grant", grant, 0);
        check("t5_async_busy", busy, 0);
        src_en = '0;
        load(1, 1, 8'h60);
        load(0, 1, 8'h61);
        drive();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_q.delete();
        #1;
        cycle();
        check("t5_port0_first", grant, 4'b0001);
        wait_q("t5_count", 2, 20);
        check("t5_q0", q_at(0), {1'b1, 8'h61});
        check("t5_q1", q_at(1), {1'b1, 8'h60});
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
